// File: rtl/acc_mem_pkg.sv
// Shared types for the accumulator-machine memory-access stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package acc_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    LOAD  = 2'd1,
    STORE = 2'd2
  } req_t;

  localparam int OPCODE_W   = 5;
  localparam int OPCODE_MSB = 15;
  localparam int OPCODE_LSB = 11;
  localparam int IMM_W      = 11;

  // data_sel encodings
  localparam logic DSEL_ALU = 1'b0;
  localparam logic DSEL_SP  = 1'b1;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Saturating BUSY-cycle counter; flags the cycle on which the limit is reached.
// Latency: hit is combinational from the current count and inc.
// Backpressure: none; counts while inc is high, holds at LIMIT.
// Ports: clk, reset (sync, active-low), clear, inc, hit.
module mem_timeout_ctr #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic hit
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (inc && (cnt != CW'(LIMIT))) begin
      cnt <= cnt + 1'b1;
    end
  end

  // The increment happening this cycle is the one that brings the count to LIMIT.
  assign hit = inc && (cnt >= CW'(LIMIT - 1));

endmodule

// File: rtl/mem_bus_ctrl.sv
// Memory-access stage: turns fetch/load/store levels into a req/ack bus cycle, owns IR and MDR.
// Latency: request in IDLE at N, BUSY from N+1 (ack accepted there), DONE pulse at N+2 minimum.
// Backpressure: stall holds the control unit until DONE; mem_ack wait states stretch BUSY.
// Ports: clk, reset (sync, active-low); fetch_req/load_req/store_req, data_sel, pc_addr,
//   alu_addr, sp_addr, wr_data from the control unit; stall, done, ir, opcode, imm, mdr back;
//   mem_req/mem_we/mem_addr/mem_wdata/mem_rdata/mem_ack bus; bus_err sticky timeout flag.
// Optional: define MEM_TIMEOUT_EN to abort BUSY after TIMEOUT_CYCLES without ack.
module mem_bus_ctrl
  import acc_mem_pkg::*;
#(
  parameter int DATA_W         = 16,
  parameter int ADDR_W         = 16,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic              load_req,
  input  logic              store_req,
  input  logic              data_sel,
  input  logic [ADDR_W-1:0] pc_addr,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [ADDR_W-1:0] sp_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              stall,
  output logic              done,
  output logic [DATA_W-1:0] ir,
  output logic [OPCODE_W-1:0] opcode,
  output logic [IMM_W-1:0]  imm,
  output logic [DATA_W-1:0] mdr,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              bus_err
);

  state_t state, state_nxt;
  req_t   req_q;
  logic   any_req;
  logic   timeout_hit;

  assign any_req = fetch_req | load_req | store_req;

`ifdef MEM_TIMEOUT_EN
  mem_timeout_ctr #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
    .clk   (clk),
    .reset (reset),
    .clear (state != BUSY),
    .inc   ((state == BUSY) && !mem_ack),
    .hit   (timeout_hit)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      bus_err <= 1'b0;
    end else if ((state == BUSY) && timeout_hit) begin
      bus_err <= 1'b1;
    end
  end
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
  assign bus_err     = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; timeout_hit already excludes an ack in the same cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = BUSY;
      BUSY:    if (mem_ack || timeout_hit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    stall   = 1'b0;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE: stall = any_req;
      BUSY: begin
        stall   = 1'b1;
        mem_req = 1'b1;
        mem_we  = (req_q == STORE);
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Request latch and IR/MDR capture. Losing simultaneous requests are simply dropped.
  always_ff @(posedge clk) begin
    if (!reset) begin
      req_q     <= FETCH;
      mem_addr  <= '0;
      mem_wdata <= '0;
      ir        <= '0;
      mdr       <= '0;
    end else begin
      if ((state == IDLE) && any_req) begin
        mem_wdata <= wr_data;
        if (fetch_req) begin
          req_q    <= FETCH;
          mem_addr <= pc_addr;
        end else begin
          req_q    <= store_req ? STORE : LOAD;
          mem_addr <= (data_sel == DSEL_SP) ? sp_addr : alu_addr;
        end
      end
      if ((state == BUSY) && mem_ack) begin
        case (req_q)
          FETCH:   ir  <= mem_rdata;
          LOAD:    mdr <= mem_rdata;
          default: ;
        endcase
      end
    end
  end

  assign opcode = ir[OPCODE_MSB:OPCODE_LSB];
  assign imm    = ir[IMM_W-1:0];

endmodule

// File: tb/tb_mem_bus_ctrl.sv
module tb_mem_bus_ctrl;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req, load_req, store_req, data_sel;
  logic [15:0] pc_addr, alu_addr, sp_addr, wr_data;
  logic        stall, done, mem_req, mem_we, bus_err, mem_ack;
  logic [15:0] ir, mdr, mem_addr, mem_wdata, mem_rdata;
  logic [4:0]  opcode;
  logic [10:0] imm;

  mem_bus_ctrl #(.DATA_W(16), .ADDR_W(16), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .load_req(load_req), .store_req(store_req),
    .data_sel(data_sel), .pc_addr(pc_addr), .alu_addr(alu_addr), .sp_addr(sp_addr),
    .wr_data(wr_data), .stall(stall), .done(done), .ir(ir), .opcode(opcode), .imm(imm),
    .mdr(mdr), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] ir;
    logic [15:0] mdr;
    logic        err;
    int          busy;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state: what IR, MDR and the error flag should hold.
  logic [15:0] m_ir, m_mdr;
  logic        m_err;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: checks bus fields on every BUSY cycle and registers on every done pulse.
  int busy_cnt = 0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        busy_cnt = 0;
      end else begin
        if (mem_req) begin
          busy_cnt++;
          if (exp_q.size() != 0) begin
            chk("mem_addr", {16'h0, mem_addr}, {16'h0, exp_q[0].addr});
            chk("mem_we", {31'h0, mem_we}, {31'h0, exp_q[0].we});
            if (exp_q[0].we) chk("mem_wdata", {16'h0, mem_wdata}, {16'h0, exp_q[0].wdata});
            chk("stall_busy", {31'h0, stall}, 32'h1);
          end
        end
        if (done) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_done", {31'h0, done}, 32'h0);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("ir", {16'h0, ir}, {16'h0, e.ir});
            chk("mdr", {16'h0, mdr}, {16'h0, e.mdr});
            chk("opcode", {27'h0, opcode}, {27'h0, e.ir[15:11]});
            chk("imm", {21'h0, imm}, {21'h0, e.ir[10:0]});
            chk("bus_err", {31'h0, bus_err}, {31'h0, e.err});
            chk("stall_done", {31'h0, stall}, 32'h0);
            chk("busy_cycles", busy_cnt, e.busy);
          end
          busy_cnt = 0;
        end
      end
    end
  end

  // Issue one request set (called just after a negedge), act as the memory, wait for done.
  task automatic run_txn(input logic f, input logic l, input logic s, input logic ds,
                         input logic [15:0] pc, input logic [15:0] alu, input logic [15:0] sp,
                         input logic [15:0] wd, input logic [15:0] rd, input int waits,
                         input bit hold);
    exp_t e;
    bit   to;
    bit   seen;
    int   busy;
`ifdef MEM_TIMEOUT_EN
    to = (waits >= TO);
`else
    to = 1'b0;
`endif
    e.we    = !f && s;
    e.addr  = f ? pc : (ds ? sp : alu);
    e.wdata = wd;
    if (!to) begin
      if (f) m_ir = rd;
      else if (!s) m_mdr = rd;
    end else begin
      m_err = 1'b1;
    end
    e.ir   = m_ir;
    e.mdr  = m_mdr;
    e.err  = m_err;
    e.busy = to ? TO : waits + 1;
    exp_q.push_back(e);

    fetch_req = f; load_req = l; store_req = s; data_sel = ds;
    pc_addr = pc; alu_addr = alu; sp_addr = sp; wr_data = wd;
    busy = 0;
    seen = 1'b0;
    for (int g = 0; g < 100; g++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (mem_req) begin
        mem_ack   = (busy == waits);
        mem_rdata = (busy == waits) ? rd : 16'($urandom);
        busy++;
      end else begin
        mem_ack = 1'b0;
      end
    end
    mem_ack = 1'b0;
    if (!hold) begin
      fetch_req = 1'b0; load_req = 1'b0; store_req = 1'b0;
    end
    if (!seen) chk("done_timeout", 32'h0, 32'h1);
  endtask

  task automatic rand_txn(input int max_wait);
    logic [2:0] r;
    r = 3'($urandom_range(1, 7));
    run_txn(r[0], r[1], r[2], 1'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
            16'($urandom), 16'($urandom), $urandom_range(0, max_wait), 1'b0);
  endtask

  initial begin
    reset = 1'b0;
    fetch_req = 1'b1; load_req = 1'b0; store_req = 1'b0; data_sel = 1'b0;
    pc_addr = 16'h0; alu_addr = 16'h0; sp_addr = 16'h0; wr_data = 16'h0;
    mem_ack = 1'b0; mem_rdata = 16'h0;
    m_ir = 16'h0; m_mdr = 16'h0; m_err = 1'b0;

    // Reset held with a fetch pending
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
    chk("rst_ir", {16'h0, ir}, 32'h0);
    chk("rst_mdr", {16'h0, mdr}, 32'h0);
    chk("rst_stall", {31'h0, stall}, 32'h1);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_bus_err", {31'h0, bus_err}, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // Zero-wait fetch: opcode 5, imm 5
    run_txn(1, 0, 0, 0, 16'h0040, 16'h1111, 16'h2222, 16'h0, 16'h2805, 0, 1'b0);
    chk("fetch_opcode", {27'h0, opcode}, 32'h5);
    chk("fetch_imm", {21'h0, imm}, 32'h5);

    // Store through sp with 3 wait states
    run_txn(0, 0, 1, 1, 16'h0, 16'h1234, 16'h7FFE, 16'hBEEF, 16'hDEAD, 3, 1'b0);

    // Load via alu address
    run_txn(0, 1, 0, 0, 16'h0, 16'h0100, 16'h7FFE, 16'h0, 16'hA5A5, 1, 1'b0);

    // All three requests held: fetch wins, then the still-held levels start another fetch
    run_txn(1, 1, 1, 1, 16'h0050, 16'h0200, 16'h0300, 16'hCAFE, 16'h1357, 0, 1'b1);
    run_txn(1, 1, 1, 1, 16'h0050, 16'h0200, 16'h0300, 16'hCAFE, 16'h2468, 2, 1'b0);

    // Reset in the middle of an unacknowledged load, then a stray ack in IDLE
    @(negedge clk);
    load_req = 1'b1; data_sel = 1'b0; alu_addr = 16'h0ABC;
    repeat (3) @(negedge clk);
    chk("mid_busy_req", {31'h0, mem_req}, 32'h1);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_mem_req", {31'h0, mem_req}, 32'h0);
    chk("mid_rst_mdr", {16'h0, mdr}, 32'h0);
    chk("mid_rst_ir", {16'h0, ir}, 32'h0);
    m_ir = 16'h0; m_mdr = 16'h0; m_err = 1'b0;
    @(negedge clk);
    reset = 1'b1; load_req = 1'b0; mem_ack = 1'b1; mem_rdata = 16'hFFFF;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("stray_ack_req", {31'h0, mem_req}, 32'h0);
      chk("stray_ack_done", {31'h0, done}, 32'h0);
      chk("stray_ack_mdr", {16'h0, mdr}, 32'h0);
    end
    @(negedge clk);
    mem_ack = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 60; i++) rand_txn(5);

`ifdef MEM_TIMEOUT_EN
    // Ack on the limit cycle is a normal completion; then a load that is never acknowledged
    run_txn(0, 1, 0, 1, 16'h0, 16'h0, 16'h4000, 16'h0, 16'h7777, TO - 1, 1'b0);
    run_txn(0, 1, 0, 0, 16'h0, 16'h4444, 16'h0, 16'h0, 16'h9999, 1000, 1'b0);
    for (int i = 0; i < 4; i++) rand_txn(5);
    @(negedge clk);
    chk("bus_err_sticky", {31'h0, bus_err}, 32'h1);
`endif

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
